// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: FSM state encoding, digit width and per-digit modulus.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    // Mixed radix: digits 3 and 5 are tens-of-seconds / tens-of-minutes.
    function automatic int digit_mod(input int idx);
        return ((idx == 3) || (idx == 5)) ? 6 : 10;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses and display outputs of the stopwatch; countdown signals appear with COUNTDOWN_EN.
interface stopwatch_if #(
    parameter int NUM_DIGITS = 6
);
    import stopwatch_pkg::*;

    logic                          start_stop;
    logic                          lap;
    logic                          clear;
    logic [DIGIT_W*NUM_DIGITS-1:0] out_time;
    logic                          running;
    logic                          lap_hold;
    logic                          tick;
    logic                          wrap;
`ifdef COUNTDOWN_EN
    logic                          dir_down;
    logic                          load;
    logic [DIGIT_W*NUM_DIGITS-1:0] preset;

    modport master (
        output start_stop, lap, clear, dir_down, load, preset,
        input  out_time, running, lap_hold, tick, wrap
    );
    modport slave (
        input  start_stop, lap, clear, dir_down, load, preset,
        output out_time, running, lap_hold, tick, wrap
    );
`else
    modport master (
        output start_stop, lap, clear,
        input  out_time, running, lap_hold, tick, wrap
    );
    modport slave (
        input  start_stop, lap, clear,
        output out_time, running, lap_hold, tick, wrap
    );
`endif

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of modulus MOD: computes the stepped value and the carry/borrow into the next digit.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic [DIGIT_W-1:0] value,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] next_value,
    output logic               carry_out,
    output logic               borrow_out
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

    logic at_max_s;
    logic at_zero_s;

    assign at_max_s   = (value >= MAX_V);
    assign at_zero_s  = (value == 4'd0);
    assign carry_out  = inc & at_max_s;
    assign borrow_out = dec & at_zero_s;

    // Step the digit up or down, wrapping at the modulus boundary.
    always_comb begin
        next_value = value;
        if (inc) begin
            next_value = at_max_s ? 4'd0 : (value + 4'd1);
        end else if (dec) begin
            next_value = at_zero_s ? MAX_V : (value - 4'd1);
        end else begin
            next_value = value;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch engine: prescaler, run/lap/pause FSM, lap register and registered display mux.
// Optional countdown with preset load is enabled by defining COUNTDOWN_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int NUM_DIGITS = 6
) (
    input  logic       clk_sys,
    input  logic       rst,
    stopwatch_if.slave bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int TW  = DIGIT_W * NUM_DIGITS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    sw_state_t       state_r, state_n;
    logic [PW-1:0]   presc_r, presc_n;
    logic [TW-1:0]   count_r, count_n;
    logic [TW-1:0]   lap_r, lap_n;
    logic [TW-1:0]   out_time_r;
    logic            running_r, lap_hold_r, tick_r, wrap_r;
    logic            wrap_n;

    logic            counting_s, step_s, dn_s, load_s;
    logic            inc_s, dec_s, terminal_s, zero_hit_s;
    logic [TW-1:0]   preset_s, step_cnt_s, tick_cnt_s;
    logic [NUM_DIGITS:0] carry_s, borrow_s;

`ifdef COUNTDOWN_EN
    function automatic logic [TW-1:0] clamp_preset(input logic [TW-1:0] raw);
        logic [TW-1:0]      res;
        logic [DIGIT_W-1:0] d;
        logic [DIGIT_W-1:0] mx;
        res = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d  = raw[i*DIGIT_W +: DIGIT_W];
            mx = DIGIT_W'(digit_mod(i) - 1);
            res[i*DIGIT_W +: DIGIT_W] = (d > mx) ? mx : d;
        end
        return res;
    endfunction

    assign dn_s     = bus.dir_down;
    assign load_s   = bus.load;
    assign preset_s = clamp_preset(bus.preset);
`else
    assign dn_s     = 1'b0;
    assign load_s   = 1'b0;
    assign preset_s = '0;
`endif

    assign counting_s  = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign step_s      = counting_s && (presc_r == PMAX);
    assign inc_s       = step_s && !dn_s;
    assign dec_s       = step_s && dn_s;
    assign carry_s[0]  = inc_s;
    assign borrow_s[0] = dec_s;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit #(
            .MOD(digit_mod(g))
        ) u_digit (
            .value     (count_r[g*DIGIT_W +: DIGIT_W]),
            .inc       (carry_s[g]),
            .dec       (borrow_s[g]),
            .next_value(step_cnt_s[g*DIGIT_W +: DIGIT_W]),
            .carry_out (carry_s[g+1]),
            .borrow_out(borrow_s[g+1])
        );
    end

    // A borrow out of the top digit means the count was already zero: hold at zero instead.
    assign tick_cnt_s = borrow_s[NUM_DIGITS] ? '0 : step_cnt_s;
    assign zero_hit_s = dec_s && !borrow_s[NUM_DIGITS] && (step_cnt_s == '0);
    assign terminal_s = dec_s && (borrow_s[NUM_DIGITS] || (step_cnt_s == '0));

    // Next-state, prescaler, count and lap-register selection with clear > start_stop > lap priority.
    always_comb begin
        state_n = state_r;
        count_n = tick_cnt_s;
        lap_n   = lap_r;
        wrap_n  = carry_s[NUM_DIGITS] | zero_hit_s;
        if (counting_s) begin
            presc_n = (presc_r == PMAX) ? '0 : (presc_r + PW'(1));
        end else begin
            presc_n = presc_r;
        end
        case (state_r)
            ST_IDLE: begin
                presc_n = '0;
                if (bus.start_stop) begin
                    state_n = ST_RUN;
                end else if (load_s) begin
                    state_n = ST_PAUSE;
                    count_n = preset_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (terminal_s || bus.start_stop) begin
                    state_n = ST_PAUSE;
                end else if (bus.lap) begin
                    state_n = ST_LAP;
                    lap_n   = count_r;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_LAP: begin
                if (terminal_s || bus.start_stop) begin
                    state_n = ST_PAUSE;
                end else if (bus.lap) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (bus.clear) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                    presc_n = '0;
                end else if (bus.start_stop) begin
                    state_n = ST_RUN;
                end else if (load_s) begin
                    state_n = ST_PAUSE;
                    count_n = preset_s;
                end else begin
                    state_n = ST_PAUSE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
                presc_n = '0;
                lap_n   = '0;
                wrap_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; display is computed from next-state values so it tracks tick.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            count_r    <= '0;
            lap_r      <= '0;
            out_time_r <= '0;
            running_r  <= 1'b0;
            lap_hold_r <= 1'b0;
            tick_r     <= 1'b0;
            wrap_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            presc_r    <= presc_n;
            count_r    <= count_n;
            lap_r      <= lap_n;
            out_time_r <= (state_n == ST_LAP) ? lap_n : count_n;
            running_r  <= (state_n == ST_RUN) || (state_n == ST_LAP);
            lap_hold_r <= (state_n == ST_LAP);
            tick_r     <= step_s;
            wrap_r     <= wrap_n;
        end
    end

    assign bus.out_time = out_time_r;
    assign bus.running  = running_r;
    assign bus.lap_hold = lap_hold_r;
    assign bus.tick     = tick_r;
    assign bus.wrap     = wrap_r;

endmodule
